// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
  parameter int WORD_SIZE = 16
);
  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_address;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_ready;

  modport master (
    output d_readM, d_writeM, d_address, d_wdata,
    input  d_rdata, d_ready
  );

  modport slave (
    input  d_readM, d_writeM, d_address, d_wdata,
    output d_rdata, d_ready
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: issues data-memory loads/stores, stalls upstream until completion,
// and presents MEM/WB latch inputs. Non-memory instructions pass through combinationally.
module mem_access_stage #(
  parameter int WORD_SIZE = 16,
  parameter int MAX_WAIT  = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ex_valid,
  input  logic                 MemRead_in,
  input  logic                 MemWrite_in,
  input  logic [WORD_SIZE-1:0] ALU_Result_in,
  input  logic [WORD_SIZE-1:0] WriteData_in,
  input  logic [1:0]           rd_in,
  input  logic                 MemtoReg_in,
  input  logic                 RegWrite_in,
  input  logic                 is_wwd_in,
  input  logic                 is_done_in,
  mem_access_stage_if.master   mem,
  output logic                 mem_stall,
  output logic                 wb_valid,
  output logic [WORD_SIZE-1:0] MemData_out,
  output logic [WORD_SIZE-1:0] ALU_Result_out,
  output logic [1:0]           rd_out,
  output logic                 MemtoReg_out,
  output logic                 RegWrite_out,
  output logic                 is_wwd_out,
  output logic                 is_done_out,
  output logic                 mem_error
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t               state_q, state_d;
  logic [7:0]           wait_q, wait_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 mem_op, is_rd, is_wr, req, fwd;

  // A read+write conflict is resolved as a read; the write is dropped.
  assign is_rd  = MemRead_in;
  assign is_wr  = MemWrite_in & ~MemRead_in;
  assign mem_op = ex_valid & (MemRead_in | MemWrite_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    req            = 1'b0;
    fwd            = 1'b0;
    mem_stall      = 1'b0;
    wb_valid       = 1'b0;
    MemData_out    = '0;
    mem.d_readM    = 1'b0;
    mem.d_writeM   = 1'b0;
    mem.d_address  = '0;
    mem.d_wdata    = '0;
    ALU_Result_out = '0;
    rd_out         = '0;
    MemtoReg_out   = 1'b0;
    RegWrite_out   = 1'b0;
    is_wwd_out     = 1'b0;
    is_done_out    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          req       = 1'b1;
          mem_stall = 1'b1;
          wait_d    = '0;
          state_d   = ACCESS;
          if (MemRead_in && MemWrite_in) err_d = 1'b1;
        end else begin
          wb_valid = ex_valid;
          fwd      = 1'b1;
        end
      end
      ACCESS: begin
        req       = 1'b1;
        mem_stall = 1'b1;
        wait_d    = wait_q + 8'd1;
        if (mem.d_ready) begin
          if (is_rd) rdata_d = mem.d_rdata;
          state_d = DONE;
        end else if (wait_q == 8'(MAX_WAIT - 1)) begin
          // Timeout: loads return all ones so software sees a poisoned value.
          rdata_d = '1;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_valid    = 1'b1;
        fwd         = 1'b1;
        MemData_out = is_rd ? rdata_q : '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (req) begin
      mem.d_readM   = is_rd;
      mem.d_writeM  = is_wr;
      mem.d_address = ALU_Result_in;
      mem.d_wdata   = WriteData_in;
    end

    if (fwd) begin
      ALU_Result_out = ALU_Result_in;
      rd_out         = rd_in;
      MemtoReg_out   = MemtoReg_in;
      RegWrite_out   = RegWrite_in;
      is_wwd_out     = is_wwd_in;
      is_done_out    = is_done_in;
    end

    // Pass-through paths are combinational, so they must be gated to read 0 in reset.
    if (!reset_n) begin
      mem_stall      = 1'b0;
      wb_valid       = 1'b0;
      MemData_out    = '0;
      mem.d_readM    = 1'b0;
      mem.d_writeM   = 1'b0;
      mem.d_address  = '0;
      mem.d_wdata    = '0;
      ALU_Result_out = '0;
      rd_out         = '0;
      MemtoReg_out   = 1'b0;
      RegWrite_out   = 1'b0;
      is_wwd_out     = 1'b0;
      is_done_out    = 1'b0;
    end
  end

  assign mem_error = err_q;
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage 16-bit pipeline, between the EX/MEM latch and the MEM/WB latch.
- Performs data-memory loads and stores over a request/ready bus and stalls the pipeline until each access completes.
- Presents the MEM/WB latch inputs: MemData, ALU_Result, rd, MemtoReg, RegWrite, is_wwd and is_done.
- Non-memory instructions pass through combinationally with zero added latency.

Parameters:
- WORD_SIZE, 16, datapath and address width.
- MAX_WAIT, 15, number of ACCESS cycles without d_ready before timeout; range 1..255.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ex_valid  input  1  EX/MEM latch holds a valid instruction.
- MemRead_in  input  1  load.
- MemWrite_in  input  1  store.
- ALU_Result_in  input  WORD_SIZE  effective address, or ALU result for non-memory instructions.
- WriteData_in  input  WORD_SIZE  store data.
- rd_in  input  2  destination register.
- MemtoReg_in, RegWrite_in, is_wwd_in, is_done_in  input  1 each  control bits forwarded to writeback.
- d_readM  output  1  memory read request.
- d_writeM  output  1  memory write request.
- d_address  output  WORD_SIZE  memory address.
- d_wdata  output  WORD_SIZE  memory write data.
- d_rdata  input  WORD_SIZE  memory read data; valid while d_ready=1.
- d_ready  input  1  one-cycle completion pulse from memory.
- mem_stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM latches.
- wb_valid  output  1  MEM/WB inputs hold a valid instruction this cycle.
- MemData_out  output  WORD_SIZE  load data.
- ALU_Result_out  output  WORD_SIZE  forwarded ALU_Result_in.
- rd_out  output  2  forwarded rd_in.
- MemtoReg_out, RegWrite_out, is_wwd_out, is_done_out  output  1 each  forwarded control bits.
- mem_error  output  1  sticky error flag.

Behaviour:
Reset:
- reset_n low forces state IDLE, wait counter 0, rdata_q 0, mem_error 0, immediately (asynchronous).
- All outputs read 0 during reset, including d_readM, d_writeM, mem_stall and wb_valid.

Operation classes:
- mem_op = ex_valid & (MemRead_in | MemWrite_in).
- If MemRead_in and MemWrite_in are both 1: treat as a read, suppress the write, set mem_error.

IDLE state:
- mem_op=0: pass-through. wb_valid=ex_valid; ALU_Result/rd/control outputs follow inputs; MemData_out=0; mem_stall=0; no request. Zero latency.
- mem_op=1: d_readM or d_writeM asserted in the same cycle; d_address=ALU_Result_in; d_wdata=WriteData_in; mem_stall=1; wb_valid=0; next edge goes to ACCESS with counter 0.

ACCESS state:
- Request, address and data held; mem_stall=1; wb_valid=0; counter increments each cycle.
- d_ready=1: for a read, capture d_rdata into rdata_q; go to DONE.
- Counter reaches MAX_WAIT with d_ready=0: rdata_q = all ones, mem_error set, go to DONE.
- d_ready in IDLE or DONE: ignored.

DONE state (exactly one cycle):
- Requests deasserted; mem_stall=0; wb_valid=1.
- MemData_out=rdata_q for a load, 0 for a store.
- Remaining outputs come from the EX/MEM inputs, which are stable because of the stall.
- Next edge returns to IDLE; MEM/WB captures and the upstream latches advance on this same edge.

Timing and boundaries:
- Access latency = 2 + (cycles until d_ready) stall cycles.
- Best case: d_ready on the first ACCESS cycle gives 2 stall cycles, then DONE.
- Back-to-back memory ops: the second op is evaluated in IDLE after DONE, never overlapped.
- Reset mid-ACCESS: request drops asynchronously; a later d_ready is ignored.
- mem_error clears only on reset.

Test Plan:
1. Reset, then ex_valid=1, MemRead_in=0, MemWrite_in=0, ALU_Result_in=16'h1234, rd_in=2, RegWrite_in=1 -> same cycle: wb_valid=1, ALU_Result_out=16'h1234, rd_out=2, mem_stall=0, no request.
2. Load from 16'h0040; memory pulses d_ready with d_rdata=16'hBEEF on the 3rd ACCESS cycle -> d_readM high 4 cycles, mem_stall high 4 cycles, then DONE with MemData_out=16'hBEEF, wb_valid=1.
3. Store 16'h00AA to 16'h0010, d_ready on the first ACCESS cycle -> d_writeM=1, d_address=16'h0010, d_wdata=16'h00AA for 2 cycles; DONE MemData_out=0.
4. Load with d_ready never asserted, MAX_WAIT=15 -> DONE after 15 ACCESS cycles, MemData_out=16'hFFFF, mem_error=1 and stays 1.
5. Assert reset_n low during ACCESS, then pulse d_ready after release -> d_readM=0 immediately; state IDLE; wb_valid stays 0; no capture.
6. MemRead_in=MemWrite_in=1 -> d_readM=1, d_writeM=0, mem_error=1; load completes normally.
